// File: rtl/fft_pkg.sv
// Shared FFT datapath helpers: element pack/unpack and the round/saturate step.
// Helpers work on 64-bit containers so any DW up to 31 fits without overflow.
package fft_pkg;

  localparam int N_DEF     = 16;
  localparam int LOG2N_DEF = 4;
  localparam int DW_DEF    = 16;

  function automatic logic signed [63:0] sext(input logic [63:0] v, input int w);
    logic [63:0] m;
    m = v << (64 - w);
    return $signed(m) >>> (64 - w);
  endfunction

  function automatic logic signed [63:0] re_of(input logic [63:0] e, input int dw);
    return sext(e >> dw, dw);
  endfunction

  function automatic logic signed [63:0] im_of(input logic [63:0] e, input int dw);
    return sext(e, dw);
  endfunction

  function automatic logic [63:0] pack(input logic [63:0] re, input logic [63:0] im,
                                       input int dw);
    logic [63:0] m;
    m = (64'd1 << dw) - 64'd1;
    return ((re & m) << dw) | (im & m);
  endfunction

  // Round half-up by sh bits, then clamp to a signed dw-bit range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] v, input int sh,
                                                   input int dw, output logic sat);
    logic signed [63:0] r, mx, mn;
    r = v;
    if (sh > 0) r = (v + (64'sd1 <<< (sh - 1))) >>> sh;
    mx  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    mn  = -(64'sd1 <<< (dw - 1));
    sat = (r > mx) || (r < mn);
    if (r > mx) r = mx;
    else if (r < mn) r = mn;
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly_stage_twiddle_rom.sv
// Constant twiddle table W^k = cos(2pi k/N) - i sin(2pi k/N), Q(TW_W-2) fixed point.
// The table is elaborated once; a constant index folds to a pair of constants.
module fft_twiddle_rom
  import fft_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int TW_W = 18
) (
  input  logic [$clog2(N)-1:0]  k_i,
  output logic signed [TW_W-1:0] wr_o,
  output logic signed [TW_W-1:0] wi_o
);

  localparam int  F  = TW_W - 2;
  localparam real PI = 3.14159265358979323846;

  function automatic real rcos(input real x);
    real term, sum;
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n <= 30; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic logic [N*2*TW_W-1:0] build_tbl();
    logic [N*2*TW_W-1:0] t;
    real ang, sc;
    t  = '0;
    sc = 1.0;
    for (int i = 0; i < F; i++) sc = sc * 2.0;
    for (int k = 0; k < N; k++) begin
      ang = 2.0 * PI * real'(k) / real'(N);
      if (ang > PI) ang = ang - 2.0 * PI;
      t[k*2*TW_W +: 2*TW_W] = {TW_W'(rnd(rcos(ang) * sc)),
                               TW_W'(rnd(-rcos(ang - PI / 2.0) * sc))};
    end
    return t;
  endfunction

  localparam logic [N*2*TW_W-1:0] TBL = build_tbl();

  logic [2*TW_W-1:0] ent;
  assign ent  = TBL[k_i*2*TW_W +: 2*TW_W];
  assign wr_o = ent[2*TW_W-1:TW_W];
  assign wi_o = ent[TW_W-1:0];

endmodule

// File: rtl/fft_bfly_stage_pipe.sv
// Two-register radix-2 DIF butterfly stage: sum/diff, then twiddle multiply,
// round, saturate. Whole pipeline stalls together when the output is blocked.
module fft_bfly_stage_pipe
  import fft_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int LOG2N = LOG2N_DEF,
  parameter int STAGE = 0,
  parameter int DW    = DW_DEF,
  parameter int TW_W  = 18,
  parameter int SCALE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [N*2*DW-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*2*DW-1:0] out_data,
  input  logic              ovf_clr,
  output logic              ovf
);

  localparam int D      = N >> (STAGE + 1);
  localparam int NP     = N / 2;
  localparam int F      = TW_W - 2;
  localparam int KW     = $clog2(N);
  localparam int STAGES = 2;
  localparam bit LAST   = (STAGE == LOG2N - 1);

  logic [STAGES:1]     vld_q;
  logic [STAGES:0]     vld_pipe;
  logic                en, inv_q, ovf_q;
  logic [N*2*DW-1:0]   out_data_d, out_data_q;
  logic [NP-1:0]       sat_p;

  assign vld_pipe  = {vld_q, in_valid};
  assign en        = !vld_pipe[STAGES] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];
  assign out_data  = out_data_q;
  assign ovf       = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      inv_q      <= 1'b0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (en) begin
        vld_q      <= vld_pipe[STAGES-1:0];
        inv_q      <= in_inv;
        out_data_q <= out_data_d;
      end
      if (ovf_clr) ovf_q <= 1'b0;
      else if (en && vld_pipe[1] && |sat_p) ovf_q <= 1'b1;
    end
  end

  if (LAST) begin : g_no_inv
    // W = 1 on the last stage, so its conjugate is irrelevant.
    logic unused_inv;
    assign unused_inv = inv_q;
  end

  for (genvar p = 0; p < NP; p++) begin : g_pair
    localparam int J = p % D;
    localparam int A = (p / D) * 2 * D + J;
    localparam int B = A + D;
    localparam int K = J << STAGE;

    logic [2*DW-1:0]     ea, eb;
    logic signed [DW:0]  sr_q, si_q, dr_q, di_q;
    logic signed [DW-1:0] ysr, ysi, ydr, ydi;
    logic [1:0]          s_sum, s_dif;

    assign ea = in_data[A*2*DW +: 2*DW];
    assign eb = in_data[B*2*DW +: 2*DW];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sr_q <= '0;
        si_q <= '0;
        dr_q <= '0;
        di_q <= '0;
      end else if (en) begin
        sr_q <= (DW+1)'(re_of(64'(ea), DW) + re_of(64'(eb), DW));
        si_q <= (DW+1)'(im_of(64'(ea), DW) + im_of(64'(eb), DW));
        dr_q <= (DW+1)'(re_of(64'(ea), DW) - re_of(64'(eb), DW));
        di_q <= (DW+1)'(im_of(64'(ea), DW) - im_of(64'(eb), DW));
      end
    end

    always_comb begin
      s_sum = '0;
      ysr   = DW'(sat_round(64'(sr_q), SCALE, DW, s_sum[0]));
      ysi   = DW'(sat_round(64'(si_q), SCALE, DW, s_sum[1]));
    end

    if (LAST) begin : g_w1
      always_comb begin
        s_dif = '0;
        ydr   = DW'(sat_round(64'(dr_q), SCALE, DW, s_dif[0]));
        ydi   = DW'(sat_round(64'(di_q), SCALE, DW, s_dif[1]));
      end
    end else begin : g_tw
      logic signed [TW_W-1:0] wr, wi;
      logic signed [63:0]     wi_e;

      fft_twiddle_rom #(.N(N), .TW_W(TW_W)) u_rom (
        .k_i  (KW'(K)),
        .wr_o (wr),
        .wi_o (wi)
      );

      assign wi_e = inv_q ? -64'(wi) : 64'(wi);

      always_comb begin
        s_dif = '0;
        ydr   = DW'(sat_round(64'(dr_q) * 64'(wr) - 64'(di_q) * wi_e, F + SCALE, DW, s_dif[0]));
        ydi   = DW'(sat_round(64'(dr_q) * wi_e + 64'(di_q) * 64'(wr), F + SCALE, DW, s_dif[1]));
      end
    end

    assign sat_p[p] = |{s_sum, s_dif};
    assign out_data_d[A*2*DW +: 2*DW] = (2*DW)'(pack(64'(ysr), 64'(ysi), DW));
    assign out_data_d[B*2*DW +: 2*DW] = (2*DW)'(pack(64'(ydr), 64'(ydi), DW));
  end

endmodule

// File: tb/tb_fft_bfly_stage_pipe.sv
// Directed bench: first stage (SCALE 0/1) and last stage share stimulus;
// expected values are hand-computed constants.
module tb_fft_bfly_stage_pipe;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int W  = N * 2 * DW;

  logic         clk = 1'b0, rst = 1'b1;
  logic         in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b1, ovf_clr = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         rdy0, rdy3, rdyc, vld0, vld3, vldc, ovf0, ovf3, ovfc;
  logic [W-1:0] d0, d3, dc;
  logic [W-1:0] t1, vs;
  int           n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  fft_bfly_stage_pipe #(.N(N), .LOG2N(4), .STAGE(0), .DW(DW), .TW_W(18), .SCALE(0)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_inv(in_inv),
    .in_data(in_data), .out_valid(vld0), .out_ready(out_ready), .out_data(d0),
    .ovf_clr(ovf_clr), .ovf(ovf0));

  fft_bfly_stage_pipe #(.N(N), .LOG2N(4), .STAGE(3), .DW(DW), .TW_W(18), .SCALE(0)) u_s3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .in_inv(in_inv),
    .in_data(in_data), .out_valid(vld3), .out_ready(out_ready), .out_data(d3),
    .ovf_clr(ovf_clr), .ovf(ovf3));

  fft_bfly_stage_pipe #(.N(N), .LOG2N(4), .STAGE(0), .DW(DW), .TW_W(18), .SCALE(1)) u_sc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyc), .in_inv(in_inv),
    .in_data(in_data), .out_valid(vldc), .out_ready(out_ready), .out_data(dc),
    .ovf_clr(ovf_clr), .ovf(ovfc));

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int re(input logic [W-1:0] v, input int k);
    logic [2*DW-1:0] e;
    e = v[k*2*DW +: 2*DW];
    return int'($signed(e[2*DW-1:DW]));
  endfunction

  function automatic int im(input logic [W-1:0] v, input int k);
    logic [2*DW-1:0] e;
    e = v[k*2*DW +: 2*DW];
    return int'($signed(e[DW-1:0]));
  endfunction

  function automatic logic [W-1:0] el(input logic [W-1:0] v, input int k, input int r,
                                      input int i);
    logic [DW-1:0] rr, ii;
    rr = r[DW-1:0];
    ii = i[DW-1:0];
    v[k*2*DW +: 2*DW] = {rr, ii};
    return v;
  endfunction

  function automatic logic [W-1:0] mk(input int r);
    return el('0, 0, r, 0);
  endfunction

  task automatic step(input logic v, input logic [W-1:0] d, input logic inv);
    in_valid = v;
    in_data  = d;
    in_inv   = inv;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_vld", vld0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_data", longint'(|d3), 0);
    rst = 1'b0;
    #1 chk("rst_rdy", rdy0, 1);
    @(negedge clk);

    // sums/diffs, 45-degree twiddle, -j twiddle, forward then inverse
    t1 = el('0, 0, 100, 50);
    t1 = el(t1, 1, 30, -20);
    t1 = el(t1, 2, 1000, 0);
    t1 = el(t1, 4, 100, 0);
    step(1'b1, t1, 1'b0);
    chk("lat_vld_early", vld3, 0);
    step(1'b1, t1, 1'b1);
    chk("lat_vld", vld3, 1);
    chk("s3_out0_re", re(d3, 0), 130);
    chk("s3_out0_im", im(d3, 0), 30);
    chk("s3_out1_re", re(d3, 1), 70);
    chk("s3_out1_im", im(d3, 1), 70);
    chk("s0_out2_re", re(d0, 2), 1000);
    chk("s0_out2_im", im(d0, 2), 0);
    chk("s0_out10_re", re(d0, 10), 707);
    chk("s0_out10_im", im(d0, 10), -707);
    chk("s0_out12_re", re(d0, 12), 0);
    chk("s0_out12_im_fwd", im(d0, 12), -100);
    chk("sc_out0_re", re(dc, 0), 50);
    chk("sc_out0_im", im(dc, 0), 25);
    chk("sc_out10_re", re(dc, 10), 354);
    chk("sc_out10_im", im(dc, 10), -354);
    step(1'b0, '0, 1'b0);
    chk("b2b_vld", vld0, 1);
    chk("s0_out12_im_inv", im(d0, 12), 100);
    chk("s0_out10_re_inv", re(d0, 10), 707);
    chk("s0_out10_im_inv", im(d0, 10), 707);
    chk("s3_out1_re_inv", re(d3, 1), 70);
    step(1'b0, '0, 1'b0);
    chk("bubble_vld", vld3, 0);
    chk("no_ovf", ovf0, 0);

    // saturation on a W=1 pair
    vs = el(el('0, 0, 32767, 0), 8, 32767, 0);
    step(1'b1, vs, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("sat_re", re(d0, 0), 32767);
    chk("sat_diff", re(d0, 8), 0);
    chk("sat_ovf", ovf0, 1);
    chk("scl_re", re(dc, 0), 32767);
    chk("scl_ovf", ovfc, 0);
    step(1'b0, '0, 1'b0);
    chk("ovf_sticky", ovf0, 1);
    ovf_clr = 1'b1;
    step(1'b0, '0, 1'b0);
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf0, 0);

    // stall with three back-to-back vectors
    step(1'b1, mk(11), 1'b0);
    step(1'b1, mk(22), 1'b0);
    chk("st_v1", re(d3, 0), 11);
    step(1'b1, mk(33), 1'b0);
    chk("st_v2", re(d3, 0), 22);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1 chk("st_rdy_lo", rdy3, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0);
      chk("st_hold", re(d3, 0), 22);
      chk("st_hold_vld", vld3, 1);
      chk("st_hold_rdy", rdy3, 0);
    end
    out_ready = 1'b1;
    step(1'b0, '0, 1'b0);
    chk("st_v3", re(d3, 0), 33);
    chk("st_v3_vld", vld3, 1);
    step(1'b0, '0, 1'b0);
    chk("st_drain", vld3, 0);

    // reset with vectors in flight
    step(1'b1, vs, 1'b0);
    step(1'b1, mk(44), 1'b0);
    step(1'b1, mk(55), 1'b0);
    chk("rf_pre_ovf", ovf0, 1);
    chk("rf_pre_out", re(d3, 0), 44);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rf_vld0", vld0, 0);
    chk("rf_vld3", vld3, 0);
    chk("rf_ovf", ovf0, 0);
    chk("rf_data", longint'(|d3), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    step(1'b1, mk(66), 1'b0);
    chk("rf_new_early", vld3, 0);
    step(1'b0, '0, 1'b0);
    chk("rf_new_vld", vld3, 1);
    chk("rf_new_s3", re(d3, 0), 66);
    chk("rf_new_s0a", re(d0, 0), 66);
    chk("rf_new_s0b", re(d0, 8), 66);
    step(1'b0, '0, 1'b0);
    chk("rf_no_dup", vld3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
